frame_sequencer: RTL

Per-frame game scheduler for the Super Hexagon datapath. It detects the start of each video frame from VGA vertical sync and owns the game-state FSM (IDLE / PLAY / DEAD). During play it issues ordered one-cycle update strobes to the player and wall blocks, and advances rotation, score, wall speed and colour inversion. It sits between the VGA controller and the player, wall and colour logic, and replaces ad-hoc per-module frame counting.

---
 rtl/frame_sequencer_if.sv | 23 ++
 rtl/frame_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer_if.sv
// Bundles the game-control inputs and per-frame outputs of frame_sequencer.
// The master side is the top-level/keyboard logic; the slave side is the sequencer.
interface frame_sequencer_if;
    logic        start;
    logic        kb_reset;
    logic        is_collision;
    logic        player_step;
    logic        move_walls;
    logic [9:0]  rotation_offset;
    logic [12:0] Score;
    logic [1:0]  State;
    logic        invert_colors;

    modport master (
        output start, kb_reset, is_collision,
        input  player_step, move_walls, rotation_offset, Score, State, invert_colors
    );

    modport slave (
        input  start, kb_reset, is_collision,
        output player_step, move_walls, rotation_offset, Score, State, invert_colors
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame game scheduler: detects frame start from VGA_VS, runs IDLE/PLAY/DEAD
// and issues ordered player/wall strobes followed by rotation/score/speed updates.
module frame_sequencer #(
    parameter int FRAMES_PER_POINT = 60,
    parameter int START_WALL_DIV   = 4,
    parameter int SPEEDUP_POINTS   = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               VGA_VS,
    frame_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [15:0] FRAME_LAST    = 16'(FRAMES_PER_POINT - 1);
    localparam logic [7:0]  PTS_LAST      = 8'(SPEEDUP_POINTS - 1);
    localparam logic [3:0]  WALL_DIV_INIT = 4'(START_WALL_DIV);
    localparam logic [12:0] SCORE_MAX     = 13'd999;

    state_t      state_q, state_d;
    logic        play_entry;

    logic        vs_s1, vs_s2, vs_s3;
    logic        frame_tick;

    logic        coll_latch;
    logic        vld_p0, vld_p1;
    logic        seq_ok, seq_go, step_walls, step_update;

    logic        player_step_q, move_walls_q, invert_q, dir_neg;
    logic [9:0]  rot_q;
    logic [12:0] score_q;
    logic [15:0] frame_cnt;
    logic [7:0]  pts_cnt;
    logic [3:0]  wall_div, wall_cnt;

    logic        frame_wrap, score_inc, speedup;

    function automatic logic [9:0] rot_next(input logic [9:0] rot, input logic neg);
        if (neg)
            return (rot == 10'd0) ? 10'd359 : rot - 10'd1;
        return (rot == 10'd359) ? 10'd0 : rot + 10'd1;
    endfunction

    function automatic logic [12:0] score_sat_inc(input logic [12:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 13'd1;
    endfunction

    // VGA_VS is asynchronous; the first two flops resolve metastability.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign frame_tick = vs_s3 & ~vs_s2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        play_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.kb_reset && bus.start) begin
                    state_d    = PLAY;
                    play_entry = 1'b1;
                end
            end
            PLAY: begin
                if (bus.kb_reset)                   state_d = IDLE;
                else if (frame_tick && coll_latch)  state_d = DEAD;
            end
            DEAD: begin
                if (bus.kb_reset) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new tick mid-sequence drops the remaining steps of the old one.
    assign seq_ok      = (state_q == PLAY) && !bus.kb_reset;
    assign seq_go      = seq_ok && frame_tick && !coll_latch;
    assign step_walls  = seq_ok && vld_p0 && !frame_tick;
    assign step_update = seq_ok && vld_p1 && !frame_tick;

    assign frame_wrap = (frame_cnt == FRAME_LAST);
    assign score_inc  = frame_wrap && (score_q != SCORE_MAX);
    assign speedup    = score_inc && (pts_cnt == PTS_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            coll_latch    <= 1'b0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            player_step_q <= 1'b0;
            move_walls_q  <= 1'b0;
            invert_q      <= 1'b0;
            dir_neg       <= 1'b0;
            rot_q         <= 10'd0;
            score_q       <= 13'd0;
            frame_cnt     <= 16'd0;
            pts_cnt       <= 8'd0;
            wall_div      <= WALL_DIV_INIT;
            wall_cnt      <= 4'd0;
        end else begin
            // Stage T+1: player update strobe
            player_step_q <= seq_go;
            vld_p0        <= seq_go;
            vld_p1        <= step_walls;

            // Stage T+2: wall advance strobe
            move_walls_q  <= step_walls && (wall_cnt == 4'd0);
            if (step_walls)
                wall_cnt <= (wall_cnt == 4'd0) ? wall_div - 4'd1 : wall_cnt - 4'd1;

            // Stage T+3: rotation, score and difficulty
            if (step_update) begin
                rot_q     <= rot_next(rot_q, dir_neg);
                frame_cnt <= frame_wrap ? 16'd0 : frame_cnt + 16'd1;
                if (score_inc) begin
                    score_q <= score_sat_inc(score_q);
                    pts_cnt <= (pts_cnt == PTS_LAST) ? 8'd0 : pts_cnt + 8'd1;
                end
                if (speedup) begin
                    dir_neg  <= ~dir_neg;
                    invert_q <= ~invert_q;
                    if (wall_div > 4'd1) wall_div <= wall_div - 4'd1;
                end
            end

            if (play_entry)
                coll_latch <= 1'b0;
            else if (state_q == PLAY && bus.is_collision)
                coll_latch <= 1'b1;

            if (play_entry) begin
                rot_q     <= 10'd0;
                score_q   <= 13'd0;
                frame_cnt <= 16'd0;
                pts_cnt   <= 8'd0;
                wall_cnt  <= 4'd0;
                wall_div  <= WALL_DIV_INIT;
                dir_neg   <= 1'b0;
                invert_q  <= 1'b0;
            end
        end
    end

    assign bus.player_step     = player_step_q;
    assign bus.move_walls      = move_walls_q;
    assign bus.rotation_offset = rot_q;
    assign bus.Score           = score_q;
    assign bus.State           = state_q;
    assign bus.invert_colors   = invert_q;

endmodule
